// File: rtl/picorv32_axil_master.sv
// Bridges the picorv32 native memory interface onto one AXI4-Lite master port.
// Every native request becomes exactly one AXI4-Lite read or write transaction.
module picorv32_axil_master #(
    parameter bit RESP_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_awaddr,
    output logic [2:0]  axi_awprot,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic [1:0]  axi_bresp,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [2:0]  axi_arprot,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t      state;
    logic        aw_done;
    logic        w_done;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  prot_q;
    logic        aw_fin;
    logic        w_fin;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return RESP_CHECK && (resp != 2'b00);
    endfunction

    // A channel counts as finished in the very cycle its handshake happens.
    assign aw_fin = aw_done || (axi_awvalid && axi_awready);
    assign w_fin  = w_done  || (axi_wvalid  && axi_wready);

    assign axi_awaddr = addr_q;
    assign axi_araddr = addr_q;
    assign axi_awprot = prot_q;
    assign axi_arprot = prot_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;

    // Payload registers only change in IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_valid && !rst) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            prot_q  <= {mem_instr, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            bus_err     <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        if (mem_wstrb == 4'b0000) begin
                            axi_arvalid <= 1'b1;
                            state       <= RD_ADDR;
                        end else begin
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            state       <= WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        mem_rdata  <= axi_rdata;
                        mem_ready  <= 1'b1;
                        if (resp_is_err(axi_rresp)) bus_err <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR_REQ: begin
                    if (axi_awvalid && axi_awready) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (axi_wvalid && axi_wready) begin
                        axi_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        axi_bready <= 1'b1;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        mem_ready  <= 1'b1;
                        if (resp_is_err(axi_bresp)) bus_err <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_axil_master.sv
// Directed bench for picorv32_axil_master with a RAM-backed AXI4-Lite slave model.
module tb_picorv32_axil_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, bus_err;
    logic [31:0] mem_rdata;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;

    // Second instance without response checking; shares all inputs.
    logic        mem_ready0, bus_err0, awvalid0, wvalid0, bready0, arvalid0, rready0;
    logic [31:0] mem_rdata0, awaddr0, wdata0, araddr0;
    logic [2:0]  awprot0, arprot0;
    logic [3:0]  wstrb0;

    picorv32_axil_master #(.RESP_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .bus_err(bus_err)
    );

    picorv32_axil_master #(.RESP_CHECK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready0), .mem_rdata(mem_rdata0),
        .axi_awvalid(awvalid0), .axi_awready(axi_awready), .axi_awaddr(awaddr0),
        .axi_awprot(awprot0), .axi_wvalid(wvalid0), .axi_wready(axi_wready),
        .axi_wdata(wdata0), .axi_wstrb(wstrb0), .axi_bvalid(axi_bvalid),
        .axi_bready(bready0), .axi_bresp(axi_bresp), .axi_arvalid(arvalid0),
        .axi_arready(axi_arready), .axi_araddr(araddr0), .axi_arprot(arprot0),
        .axi_rvalid(axi_rvalid), .axi_rready(rready0), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .bus_err(bus_err0)
    );

    // Slave: either driven by hand (manual) or by the reactive RAM model.
    logic        manual, rnd;
    logic [1:0]  rresp_cfg, bresp_cfg;
    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata;
    logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid, s_aw_got, s_w_got;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    logic [31:0] ram [0:255];
    logic        awh, wh;

    assign axi_arready = manual ? m_arready : s_arready;
    assign axi_awready = manual ? m_awready : s_awready;
    assign axi_wready  = manual ? m_wready  : s_wready;
    assign axi_rvalid  = manual ? m_rvalid  : s_rvalid;
    assign axi_bvalid  = manual ? m_bvalid  : s_bvalid;
    assign axi_rdata   = manual ? m_rdata   : s_rdata;
    assign axi_rresp   = manual ? 2'b00     : s_rresp;
    assign axi_bresp   = manual ? 2'b00     : s_bresp;

    function automatic logic [31:0] rom_word(input int i);
        return (i == 32) ? 32'h0841_0113 : (32'hC0DE_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        awh = axi_awvalid && axi_awready;
        wh  = axi_wvalid && axi_wready;
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= rom_word(i);
        end else if (!manual && wh) begin
            for (int b = 0; b < 4; b++)
                if (axi_wstrb[b]) ram[axi_awaddr[9:2]][8*b +: 8] <= axi_wdata[8*b +: 8];
        end
        if (rst || manual) begin
            s_arready <= 1'b1; s_awready <= 1'b1; s_wready <= 1'b1;
            s_rvalid <= 1'b0; s_bvalid <= 1'b0; s_aw_got <= 1'b0; s_w_got <= 1'b0;
            s_rdata <= '0; s_rresp <= 2'b00; s_bresp <= 2'b00;
        end else begin
            s_arready <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_awready <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wready  <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi_arvalid && axi_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= ram[axi_araddr[9:2]];
                s_rresp  <= rresp_cfg;
            end else if (s_rvalid && axi_rready) begin
                s_rvalid <= 1'b0;
            end
            if ((s_aw_got || awh) && (s_w_got || wh) && !s_bvalid) begin
                s_bvalid <= 1'b1; s_bresp <= bresp_cfg;
                s_aw_got <= 1'b0; s_w_got <= 1'b0;
            end else begin
                if (awh) s_aw_got <= 1'b1;
                if (wh)  s_w_got  <= 1'b1;
            end
            if (s_bvalid && axi_bready) s_bvalid <= 1'b0;
        end
    end

    // Protocol monitor: a valid must stay high with stable payload until its handshake.
    int          proto_err = 0, rdy_cnt = 0;
    logic        p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    always @(posedge clk) begin
        if (mem_ready) rdy_cnt <= rdy_cnt + 1;
        if (rst) begin
            p_ar <= 1'b0; p_aw <= 1'b0; p_w <= 1'b0;
        end else begin
            if ((p_ar && (!axi_arvalid || axi_araddr !== p_araddr)) ||
                (p_aw && (!axi_awvalid || axi_awaddr !== p_awaddr)) ||
                (p_w  && (!axi_wvalid  || axi_wdata  !== p_wdata)))
                proto_err <= proto_err + 1;
            p_ar <= axi_arvalid && !axi_arready; p_araddr <= axi_araddr;
            p_aw <= axi_awvalid && !axi_awready; p_awaddr <= axi_awaddr;
            p_w  <= axi_wvalid  && !axi_wready;  p_wdata  <= axi_wdata;
        end
    end

    int vectors = 0, miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic instr, output logic [31:0] rd, output int lat);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = instr;
        lat = -1; rd = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (mem_ready) begin
                lat = c; rd = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({mem_ready, axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready, bus_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready/ar/aw/w/rr/br/err=%b want 0000000",
                     {mem_ready, axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready, bus_err});
        end
        vectors++;
        if (mem_rdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %h want 00000000", mem_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_rom();
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h80; mem_wstrb = 4'b0;
        tick();
        vectors++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h80 || axi_arprot !== 3'b100) begin
            miscompares++;
            $display("FAIL read_ar: arvalid=%b araddr=%h arprot=%b want 1 00000080 100",
                     axi_arvalid, axi_araddr, axi_arprot);
        end
        tick();
        vectors++;
        if (axi_rready !== 1'b1 || mem_ready !== 1'b0) begin
            miscompares++; $display("FAIL read_c2: rready=%b mem_ready=%b want 1 0", axi_rready, mem_ready);
        end
        tick();
        vectors++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h0841_0113) begin
            miscompares++; $display("FAIL read_c3: mem_ready=%b rdata=%h want 1 08410113", mem_ready, mem_rdata);
        end
        mem_valid = 1'b0; mem_instr = 1'b0;
        tick();
        vectors++;
        if (mem_ready !== 1'b0 || axi_rready !== 1'b0) begin
            miscompares++; $display("FAIL read_c4: mem_ready=%b rready=%b want 0 0", mem_ready, axi_rready);
        end
    endtask

    task automatic test_write_wdelay();
        manual = 1'b1; m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; m_rdata = '0;
        mem_valid = 1'b1; mem_addr = 32'h0002_0000; mem_wdata = 32'h0000_FFFF; mem_wstrb = 4'b0011;
        tick();
        vectors++;
        if ({axi_awvalid, axi_wvalid} !== 2'b11 || axi_awaddr !== 32'h0002_0000 || axi_wdata !== 32'h0000_FFFF ||
            axi_wstrb !== 4'b0011 || axi_awprot !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_c1: aw/w=%b awaddr=%h wdata=%h wstrb=%b prot=%b want 11 00020000 0000ffff 0011 000",
                     {axi_awvalid, axi_wvalid}, axi_awaddr, axi_wdata, axi_wstrb, axi_awprot);
        end
        m_awready = 1'b1;
        tick(); m_awready = 1'b0;
        vectors++;
        if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b010) begin
            miscompares++; $display("FAIL wr_c2: aw/w/b=%b want 010", {axi_awvalid, axi_wvalid, axi_bready});
        end
        tick();
        vectors++;
        if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b010) begin
            miscompares++; $display("FAIL wr_c3: aw/w/b=%b want 010", {axi_awvalid, axi_wvalid, axi_bready});
        end
        tick();
        vectors++;
        if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b010) begin
            miscompares++; $display("FAIL wr_c4: aw/w/b=%b want 010", {axi_awvalid, axi_wvalid, axi_bready});
        end
        m_wready = 1'b1;
        tick(); m_wready = 1'b0;
        vectors++;
        if ({axi_awvalid, axi_wvalid, axi_bready, mem_ready} !== 4'b0010) begin
            miscompares++; $display("FAIL wr_c5: aw/w/b/rdy=%b want 0010", {axi_awvalid, axi_wvalid, axi_bready, mem_ready});
        end
        tick(); m_bvalid = 1'b1;
        vectors++;
        if ({axi_bready, mem_ready} !== 2'b10) begin
            miscompares++; $display("FAIL wr_c6: bready/rdy=%b want 10", {axi_bready, mem_ready});
        end
        tick(); m_bvalid = 1'b0;
        vectors++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h0841_0113) begin
            miscompares++; $display("FAIL wr_c7: mem_ready=%b rdata=%h want 1 08410113", mem_ready, mem_rdata);
        end
        mem_valid = 1'b0; mem_wstrb = 4'b0;
        tick();
        vectors++;
        if ({axi_bready, mem_ready} !== 2'b00) begin
            miscompares++; $display("FAIL wr_c8: bready/rdy=%b want 00", {axi_bready, mem_ready});
        end
        manual = 1'b0;
        tick();
    endtask

    task automatic test_bus_err();
        logic [31:0] rd;
        int lat;
        rresp_cfg = 2'b10;
        do_req(32'h10, '0, 4'b0, 1'b0, rd, lat);
        rresp_cfg = 2'b00;
        vectors++;
        if (lat !== 3 || rd !== 32'hC0DE_0004) begin
            miscompares++; $display("FAIL err_read: lat=%0d rdata=%h want 3 c0de0004", lat, rd);
        end
        vectors++;
        if ({bus_err, bus_err0} !== 2'b10) begin
            miscompares++; $display("FAIL err_set: bus_err/nocheck=%b want 10", {bus_err, bus_err0});
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 1) do_req(32'h200, 32'hAABB_CCDD, 4'b1111, 1'b0, rd, lat);
            else        do_req(32'h200, '0, 4'b0, 1'b0, rd, lat);
            vectors++;
            if (lat < 0 || {bus_err, bus_err0} !== 2'b10 || (k == 2 && rd !== 32'hAABB_CCDD)) begin
                miscompares++;
                $display("FAIL err_sticky%0d: lat=%0d err/nocheck=%b rdata=%h want err 10", k, lat, {bus_err, bus_err0}, rd);
            end
            vectors++;
            if ({mem_ready0, mem_rdata0, awvalid0, wvalid0, bready0, arvalid0, rready0, awaddr0, wdata0, araddr0,
                 awprot0, arprot0, wstrb0} !==
                {mem_ready, mem_rdata, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, axi_awaddr,
                 axi_wdata, axi_araddr, axi_awprot, axi_arprot, axi_wstrb}) begin
                miscompares++; $display("FAIL err_twin%0d: RESP_CHECK=0 outputs differ (rdata %h vs %h)", k, mem_rdata0, mem_rdata);
            end
        end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (bus_err !== 1'b0) begin
            miscompares++; $display("FAIL err_clear: bus_err=%b want 0", bus_err);
        end
        bresp_cfg = 2'b10;
        do_req(32'h204, 32'h1234_5678, 4'b1111, 1'b0, rd, lat);
        bresp_cfg = 2'b00;
        vectors++;
        if (lat !== 3 || {bus_err, bus_err0} !== 2'b10) begin
            miscompares++; $display("FAIL err_bresp: lat=%0d err/nocheck=%b want 3 10", lat, {bus_err, bus_err0});
        end
        tick();
    endtask

    task automatic test_stall();
        manual = 1'b1; m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        mem_valid = 1'b1; mem_addr = 32'h84; mem_wstrb = 4'b0;
        tick();
        for (int c = 1; c <= 10; c++) begin
            vectors++;
            if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h84 || mem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_c%0d: arvalid=%b araddr=%h mem_ready=%b want 1 00000084 0", c, axi_arvalid, axi_araddr, mem_ready);
            end
            tick();
        end
        m_arready = 1'b1;
        tick(); m_arready = 1'b0;
        vectors++;
        if ({axi_arvalid, axi_rready, mem_ready} !== 3'b010) begin
            miscompares++; $display("FAIL stall_r: ar/rr/rdy=%b want 010", {axi_arvalid, axi_rready, mem_ready});
        end
        m_rvalid = 1'b1; m_rdata = 32'hC0DE_0021;
        tick(); m_rvalid = 1'b0;
        vectors++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hC0DE_0021) begin
            miscompares++; $display("FAIL stall_done: mem_ready=%b rdata=%h want 1 c0de0021", mem_ready, mem_rdata);
        end
        mem_valid = 1'b0;
        manual = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd;
        int lat;
        manual = 1'b1; m_arready = 1'b1; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        mem_valid = 1'b1; mem_addr = 32'h88; mem_wstrb = 4'b0;
        tick(); tick(); m_arready = 1'b0;
        vectors++;
        if (axi_rready !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre: rready=%b want 1", axi_rready);
        end
        rst = 1'b1; mem_valid = 1'b0;
        tick(); rst = 1'b0;
        vectors++;
        if ({axi_rready, mem_ready, axi_arvalid, axi_awvalid, axi_wvalid, axi_bready} !== 6'b0 || mem_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid: rr/rdy/ar/aw/w/br=%b rdata=%h want 000000 00000000",
                     {axi_rready, mem_ready, axi_arvalid, axi_awvalid, axi_wvalid, axi_bready}, mem_rdata);
        end
        manual = 1'b0;
        do_req(32'h80, '0, 4'b0, 1'b1, rd, lat);
        vectors++;
        if (lat !== 3 || rd !== 32'h0841_0113) begin
            miscompares++; $display("FAIL rst_fresh: lat=%0d rdata=%h want 3 08410113", lat, rd);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_t [8] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h10C, 32'h10C};
        logic [31:0] d_t [8] = '{32'h1111_1111, 0, 32'h2222_2222, 0, 32'h3333_3333, 0, 32'h4444_4444, 0};
        logic [3:0]  s_t [8] = '{4'b1111, 0, 4'b0101, 0, 4'b1000, 0, 4'b0110, 0};
        logic [31:0] e_t [8] = '{0, 32'h1111_1111, 0, 32'hC022_0022, 0, 32'h33DE_0042, 0, 32'hC044_4443};
        logic [31:0] rd;
        int lat, rdy0;
        rnd = 1'b1;
        rdy0 = rdy_cnt;
        for (int i = 0; i < 8; i++) begin
            do_req(a_t[i], d_t[i], s_t[i], 1'b0, rd, lat);
            vectors++;
            if (lat < 0 || (s_t[i] == 4'b0 && rd !== e_t[i])) begin
                miscompares++; $display("FAIL b2b_%0d: lat=%0d rdata=%h want done, %h", i, lat, rd, e_t[i]);
            end
        end
        rnd = 1'b0;
        tick(); tick();
        vectors++;
        if (rdy_cnt - rdy0 !== 8) begin
            miscompares++; $display("FAIL b2b_ready_count: got %0d pulses want 8", rdy_cnt - rdy0);
        end
        vectors++;
        if (proto_err !== 0) begin
            miscompares++; $display("FAIL valid_stable: %0d early valid drops or payload changes, want 0", proto_err);
        end
    endtask

    initial begin
        rst = 1'b1; mem_valid = 0; mem_instr = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        manual = 0; rnd = 0; rresp_cfg = 2'b00; bresp_cfg = 2'b00;
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; m_rdata = '0;
        test_reset();
        test_read_rom();
        test_write_wdelay();
        test_bus_err();
        test_stall();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
